// File: rtl/alu_exec_if.sv
// Request/response bundle for the ALU execution unit.
// start is a request the unit takes only while busy is low; done is a one-cycle
// response strobe with result/zero held until the next done. There is no backpressure.
interface alu_exec_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      ALUOp;
  logic            opb5;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic            funct7b0;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            zero;

  modport master (
    output start, ALUOp, opb5, funct3, funct7b5, funct7b0, SrcA, SrcB,
    input  busy, done, result, zero
  );

  modport slave (
    input  start, ALUOp, opb5, funct3, funct7b5, funct7b0, SrcA, SrcB,
    output busy, done, result, zero
  );
endinterface

// File: rtl/alu_exec_unit.sv
// RV-style integer execution unit: single-cycle base ALU and multiplies,
// iterative restoring divider (one quotient bit per cycle) for DIV/DIVU/REM/REMU.
module alu_exec_unit #(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 1
) (
  input  logic       clk,
  input  logic       reset,
  alu_exec_if.slave  bus,
  output logic       state_dbg
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic {IDLE = 1'b0, DIV = 1'b1} state_t;

  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_SUB  = 4'b0001;
  localparam logic [3:0] C_AND  = 4'b0010;
  localparam logic [3:0] C_OR   = 4'b0011;
  localparam logic [3:0] C_XOR  = 4'b0100;
  localparam logic [3:0] C_SLT  = 4'b0101;
  localparam logic [3:0] C_SLL  = 4'b0110;
  localparam logic [3:0] C_SRL  = 4'b0111;
  localparam logic [3:0] C_SRA  = 4'b1000;
  localparam logic [3:0] C_SLTU = 4'b1001;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] dq;     // dividend shifting out / quotient shifting in
  logic [XLEN-1:0] dr;     // partial remainder
  logic [XLEN-1:0] dd;     // divisor magnitude
  logic            neg_q;
  logic            neg_r;
  logic            rem_sel;

  assign state_dbg = state;

  logic            m_sel;
  logic [3:0]      alu_ctl;
  logic [XLEN-1:0] alu_res;
  logic [SW-1:0]   shamt;

  assign m_sel = (ENABLE_M != 0) && (bus.ALUOp == 2'b10) && bus.opb5 && bus.funct7b0;
  assign shamt = bus.SrcB[SW-1:0];

  always_comb begin
    alu_ctl = C_ADD;
    case (bus.ALUOp)
      2'b01: alu_ctl = C_SUB;
      2'b10: begin
        case (bus.funct3)
          3'b000: alu_ctl = (bus.opb5 && bus.funct7b5) ? C_SUB : C_ADD;
          3'b001: alu_ctl = bus.funct7b5 ? C_ADD : C_SLL;
          3'b010: alu_ctl = (bus.opb5 && bus.funct7b5) ? C_ADD : C_SLT;
          3'b011: alu_ctl = (bus.opb5 && bus.funct7b5) ? C_ADD : C_SLTU;
          3'b100: alu_ctl = (bus.opb5 && bus.funct7b5) ? C_ADD : C_XOR;
          3'b101: alu_ctl = bus.funct7b5 ? C_SRA : C_SRL;
          3'b110: alu_ctl = (bus.opb5 && bus.funct7b5) ? C_ADD : C_OR;
          default: alu_ctl = (bus.opb5 && bus.funct7b5) ? C_ADD : C_AND;
        endcase
      end
      default: alu_ctl = C_ADD;
    endcase
  end

  always_comb begin
    alu_res = bus.SrcA + bus.SrcB;
    case (alu_ctl)
      C_SUB:  alu_res = bus.SrcA - bus.SrcB;
      C_AND:  alu_res = bus.SrcA & bus.SrcB;
      C_OR:   alu_res = bus.SrcA | bus.SrcB;
      C_XOR:  alu_res = bus.SrcA ^ bus.SrcB;
      C_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.SrcA) < $signed(bus.SrcB)};
      C_SLTU: alu_res = {{(XLEN-1){1'b0}}, bus.SrcA < bus.SrcB};
      C_SLL:  alu_res = bus.SrcA << shamt;
      C_SRL:  alu_res = bus.SrcA >> shamt;
      C_SRA:  alu_res = XLEN'($signed(bus.SrcA) >>> shamt);
      default: alu_res = bus.SrcA + bus.SrcB;
    endcase
  end

  // Extending both operands to 2*XLEN makes one unsigned multiply serve all MUL variants.
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    mul_a = {{XLEN{1'b0}}, bus.SrcA};
    mul_b = {{XLEN{1'b0}}, bus.SrcB};
    if (bus.funct3 == 3'b001 || bus.funct3 == 3'b010)
      mul_a = {{XLEN{bus.SrcA[XLEN-1]}}, bus.SrcA};
    if (bus.funct3 == 3'b001)
      mul_b = {{XLEN{bus.SrcB[XLEN-1]}}, bus.SrcB};
    prod    = mul_a * mul_b;
    mul_res = (bus.funct3 == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  logic            div_signed, want_rem, a_neg, b_neg, div0, ovf, is_div;
  logic [XLEN-1:0] a_mag, b_mag, special_res, fast_res;

  assign is_div     = m_sel && bus.funct3[2];
  assign div_signed = !bus.funct3[0];
  assign want_rem   = bus.funct3[1];
  assign a_neg      = div_signed && bus.SrcA[XLEN-1];
  assign b_neg      = div_signed && bus.SrcB[XLEN-1];
  assign a_mag      = a_neg ? (~bus.SrcA + 1'b1) : bus.SrcA;
  assign b_mag      = b_neg ? (~bus.SrcB + 1'b1) : bus.SrcB;
  assign div0       = (bus.SrcB == '0);
  assign ovf        = div_signed && (bus.SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (bus.SrcB == '1);

  always_comb begin
    if (div0) special_res = want_rem ? bus.SrcA : '1;
    else      special_res = want_rem ? '0 : bus.SrcA;
    if (!m_sel)      fast_res = alu_res;
    else if (is_div) fast_res = special_res;
    else             fast_res = mul_res;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  logic [XLEN:0]   rem_sh, diff;
  logic            ge;
  logic [XLEN-1:0] nr, nq, q_out, r_out, fin;

  always_comb begin
    rem_sh = {dr, dq[XLEN-1]};
    diff   = rem_sh - {1'b0, dd};
    ge     = !diff[XLEN];
    nr     = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    nq     = {dq[XLEN-2:0], ge};
    q_out  = neg_q ? (~nq + 1'b1) : nq;
    r_out  = neg_r ? (~nr + 1'b1) : nr;
    fin    = rem_sel ? r_out : q_out;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.result <= '0;
      bus.zero <= 1'b1;
      cnt      <= '0;
      dq       <= '0;
      dr       <= '0;
      dd       <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      rem_sel  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (is_div && !div0 && !ovf) begin
              state    <= DIV;
              bus.busy <= 1'b1;
              cnt      <= CW'(XLEN);
              dq       <= a_mag;
              dr       <= '0;
              dd       <= b_mag;
              neg_q    <= a_neg ^ b_neg;
              neg_r    <= a_neg;
              rem_sel  <= want_rem;
            end else begin
              bus.result <= fast_res;
              bus.zero   <= (fast_res == '0);
              bus.done   <= 1'b1;
            end
          end
        end
        DIV: begin
          dq  <= nq;
          dr  <= nr;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state      <= IDLE;
            bus.busy   <= 1'b0;
            bus.result <= fin;
            bus.zero   <= (fin == '0);
            bus.done   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed corner cases plus randomized ops
// checked against an arithmetic reference model.
module tb_alu_exec_unit;

  logic clk;
  logic reset;
  logic state_dbg;
  int   cyc;
  int   errors;
  int   checks;

  logic [31:0] exp_q[$];
  int          exp_t[$];
  logic [31:0] er;
  int          et;

  alu_exec_if #(.XLEN(32)) bus();

  alu_exec_unit #(.XLEN(32), .ENABLE_M(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: result and extra edges beyond the single-cycle case
  function automatic void model(input logic [1:0] op, input logic ob5, input logic [2:0] f3,
                                input logic f75, input logic f70, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r, output int extra);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    int              sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    sh = int'(b[4:0]);
    extra = 0;
    r = a + b;
    if (op == 2'b01) r = a - b;
    else if (op != 2'b10) r = a + b;
    else if (ob5 && f70) begin
      case (f3)
        3'd0: begin p = sa * sb; r = p[31:0]; end
        3'd1: begin p = sa * sb; r = p[63:32]; end
        3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
        3'd3: begin p = ua * ub; r = p[63:32]; end
        3'd4: begin
          if (b == 32'd0) r = 32'hFFFF_FFFF;
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
          else begin p = sa / sb; r = p[31:0]; extra = 32; end
        end
        3'd5: begin
          if (b == 32'd0) r = 32'hFFFF_FFFF;
          else begin r = a / b; extra = 32; end
        end
        3'd6: begin
          if (b == 32'd0) r = a;
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
          else begin p = sa % sb; r = p[31:0]; extra = 32; end
        end
        default: begin
          if (b == 32'd0) r = a;
          else begin r = a % b; extra = 32; end
        end
      endcase
    end else begin
      case (f3)
        3'd0: r = (ob5 && f75) ? a - b : a + b;
        3'd1: r = f75 ? a + b : a << sh;
        3'd2: r = (ob5 && f75) ? a + b : ((sa < sb) ? 32'd1 : 32'd0);
        3'd3: r = (ob5 && f75) ? a + b : ((a < b) ? 32'd1 : 32'd0);
        3'd4: r = (ob5 && f75) ? a + b : a ^ b;
        3'd5: begin p = sa >>> sh; r = f75 ? p[31:0] : a >> sh; end
        3'd6: r = (ob5 && f75) ? a + b : a | b;
        default: r = (ob5 && f75) ? a + b : a & b;
      endcase
    end
  endfunction

  // driver: waits for an idle unit, presents one request for one edge
  task automatic issue(input logic [1:0] op, input logic ob5, input logic [2:0] f3,
                       input logic f75, input logic f70, input logic [31:0] a,
                       input logic [31:0] b, input bit use_exp, input logic [31:0] ev);
    int          guard;
    logic [31:0] r;
    int          extra;
    guard = 0;
    @(negedge clk);
    while (bus.busy && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: busy=%0b after %0d cycles, required busy=0", bus.busy, guard);
      return;
    end
    bus.ALUOp = op; bus.opb5 = ob5; bus.funct3 = f3;
    bus.funct7b5 = f75; bus.funct7b0 = f70; bus.SrcA = a; bus.SrcB = b;
    bus.start = 1'b1;
    model(op, ob5, f3, f75, f70, a, b, r, extra);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    exp_q.push_back(use_exp ? ev : r);
    exp_t.push_back(cyc + extra);
  endtask

  // monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: result=%h at cycle %0d, required no done", bus.result, cyc);
      end else begin
        er = exp_q.pop_front();
        et = exp_t.pop_front();
        checks += 3;
        if (bus.result !== er) begin
          errors++;
          $display("FAIL result: got %h required %h (cycle %0d)", bus.result, er, cyc);
        end
        if (bus.zero !== (er == 32'd0)) begin
          errors++;
          $display("FAIL zero: got %0b required %0b (result %h)", bus.zero, (er == 32'd0), er);
        end
        if (cyc != et) begin
          errors++;
          $display("FAIL latency: done at cycle %0d required cycle %0d", cyc, et);
        end
      end
    end
  end

  task automatic check_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0b required %0b", name, got, req);
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    int guard;
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.ALUOp = 2'b00; bus.opb5 = 1'b0; bus.funct3 = 3'd0;
    bus.funct7b5 = 1'b0; bus.funct7b0 = 1'b0; bus.SrcA = '0; bus.SrcB = '0;
    #3;
    check_bit("reset_busy", bus.busy, 1'b0);
    check_bit("reset_done", bus.done, 1'b0);
    check_bit("reset_zero", bus.zero, 1'b1);
    checks++;
    if (bus.result !== 32'd0) begin
      errors++;
      $display("FAIL reset_result: got %h required 00000000", bus.result);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // directed corner cases
    issue(2'b10, 1'b1, 3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 1'b1, 32'd12);
    issue(2'b01, 1'b0, 3'b000, 1'b0, 1'b0, 32'h1234, 32'h1234, 1'b1, 32'd0);
    issue(2'b10, 1'b0, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 1'b1, 32'hF800_0000);
    issue(2'b10, 1'b1, 3'b011, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE);

    // DIVU with a start pulse injected mid-divide
    issue(2'b10, 1'b1, 3'b101, 1'b0, 1'b1, 32'd100, 32'd7, 1'b1, 32'd14);
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 100) begin
      n++;
      if (n == 5) begin
        bus.ALUOp = 2'b00; bus.SrcA = 32'd1; bus.SrcB = 32'd1; bus.start = 1'b1;
      end
      if (n == 6) bus.start = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL divu_busy_cycles: got %0d required 32", n);
    end

    issue(2'b10, 1'b1, 3'b111, 1'b0, 1'b1, 32'd100, 32'd7, 1'b1, 32'd2);
    issue(2'b10, 1'b1, 3'b100, 1'b0, 1'b1, 32'hFFFF_FFF7, 32'd0, 1'b1, 32'hFFFF_FFFF);
    issue(2'b10, 1'b1, 3'b110, 1'b0, 1'b1, 32'hFFFF_FFF7, 32'd0, 1'b1, 32'hFFFF_FFF7);
    issue(2'b10, 1'b1, 3'b100, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000);
    issue(2'b10, 1'b1, 3'b100, 1'b0, 1'b1, 32'hFFFF_FFF7, 32'd2, 1'b1, 32'hFFFF_FFFC);
    issue(2'b10, 1'b1, 3'b110, 1'b0, 1'b1, 32'hFFFF_FFF7, 32'd2, 1'b1, 32'hFFFF_FFFF);

    // reset in the middle of a signed divide
    issue(2'b10, 1'b1, 3'b100, 1'b0, 1'b1, 32'd1000, 32'd3, 1'b1, 32'd333);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    exp_q.delete();
    exp_t.delete();
    check_bit("abort_busy", bus.busy, 1'b0);
    check_bit("abort_done", bus.done, 1'b0);
    check_bit("abort_zero", bus.zero, 1'b1);
    check_bit("abort_state", state_dbg, 1'b0);
    checks++;
    if (bus.result !== 32'd0) begin
      errors++;
      $display("FAIL abort_result: got %h required 00000000", bus.result);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check_bit("post_abort_busy", bus.busy, 1'b0);

    // randomized traffic, gaps of 0..2 idle cycles exercise back-to-back issue
    for (int i = 0; i < 150; i++) begin
      logic [1:0] op;
      op = ($urandom_range(0, 9) < 8) ? 2'b10 : 2'($urandom_range(0, 3));
      issue(op, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), rand_operand(), rand_operand(), 1'b0, 32'd0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter XLEN, default 32: operand/result width; SHALL be 32 or 64.
REQ-002 Parameter ENABLE_M, default 1: 1 enables the M-extension ops (MUL/DIV/REM); 0 decodes them as base ops.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request; sampled only when busy=0.
REQ-006 ALUOp  in  2  00 add, 01 sub, 10 decode funct fields, 11 add.
REQ-007 opb5  in  1  opcode bit 5; 0 = I-type ALU, 1 = R-type.
REQ-008 funct3  in  3  operation select.
REQ-009 funct7b5  in  1  sub/sra select.
REQ-010 funct7b0  in  1  M-extension select (R-type only).
REQ-011 SrcA, SrcB  in  XLEN each  operands.
REQ-012 busy  out  1  high while a division is iterating.
REQ-013 done  out  1  one-cycle pulse; result valid.
REQ-014 result  out  XLEN  registered result; held until the next done.
REQ-015 zero  out  1  registered; high when result==0, updated with result.

Function
REQ-016 Base decode SHALL produce ALUControl codes: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sll 0110, srl 0111, sra 1000, sltu 1001.
REQ-017 ALUOp=10, opb5=0: funct3 000 add, 001 sll when funct7b5=0 (else add), 010 slt, 011 sltu, 100 xor, 101 sra/srl by funct7b5, 110 or, 111 and.
REQ-018 ALUOp=10, opb5=1, M op not selected: funct3 000 sub/add by funct7b5, 101 sra/srl by funct7b5; all other funct3 with funct7b5=1 decode as add.
REQ-019 Shift amount SHALL be SrcB[log2(XLEN)-1:0]; sra sign-fills from SrcA[XLEN-1].
REQ-020 slt compares signed, sltu unsigned; result is zero-extended 0/1.
REQ-021 M op selected iff ENABLE_M=1, ALUOp=10, opb5=1, funct7b0=1; funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-022 Base ops and MUL* SHALL complete in one cycle: start sampled at edge E0 -> result/zero/done updated at E0, done high for exactly the following cycle.
REQ-023 MUL returns low XLEN bits of the 2*XLEN product; MULH*/MULHU return high XLEN bits with signed/signed, signed/unsigned, unsigned/unsigned operands respectively.
REQ-024 State machine: IDLE, DIV. IDLE + start + DIV/DIVU/REM/REMU (not a special case) -> DIV at E0; counter loads XLEN; busy=1.
REQ-025 DIV: one restoring quotient bit per cycle on magnitudes; counter decrements each edge; at the edge where counter reaches 0, sign-correct quotient/remainder, register result, pulse done, return to IDLE. Latency = XLEN cycles from E0.
REQ-026 Signed divide: quotient negative iff operand signs differ; remainder takes dividend's sign.
REQ-027 Divide by zero: single-cycle; quotient = all ones, remainder = SrcA.
REQ-028 Signed overflow (SrcA = most-negative, SrcB = -1): single-cycle; quotient = SrcA, remainder = 0.
REQ-029 start while busy=1 SHALL be ignored; inputs are not re-sampled during DIV; operands are captured at E0.
REQ-030 start in the cycle done is high SHALL be accepted (back-to-back).
REQ-031 ALUOp 11 and unlisted encodings SHALL execute add.

Reset
REQ-032 reset=1 SHALL immediately force state=IDLE, busy=0, done=0, result=0, zero=1, counter=0, independent of clk.
REQ-033 Reset during DIV SHALL abort the division with no done pulse; start is accepted at the first edge after reset deasserts.

Verification
REQ-034 ADD: ALUOp=10, opb5=1, funct3=000, f7b5=0, A=5, B=7 -> done next cycle, result=12, zero=0.
REQ-035 SUB equal: ALUOp=01, A=B=0x1234 -> result=0, zero=1, 1-cycle latency.
REQ-036 SRAI: opb5=0, funct3=101, f7b5=1, A=0x80000000, B=4 -> result=0xF8000000.
REQ-037 DIVU A=100, B=7 -> busy high 32 cycles, done at cycle 32, result=14; REMU same operands -> 2; start pulsed mid-divide ignored.
REQ-038 DIV A=-9 (0xFFFFFFF7), B=0 -> 1 cycle, result=0xFFFFFFFF; REM -> 0xFFFFFFF7; DIV 0x80000000 / -1 -> 0x80000000.
REQ-039 MULHU A=B=0xFFFFFFFF -> result=0xFFFFFFFE; reset asserted at DIV cycle 10 -> busy=0, done=0, result=0 at once, no later done.
